// File: rtl/safe_sync_barrier_pkg.sv
// safe_sync_barrier_pkg
// Shared types for the dual-core rendezvous barrier.
//   NumCores : number of cores that can take part in a rendezvous
//   mask_t   : one participation/arrival bit per core, bit0 = core 0
//   state_e  : barrier sequencer states
package safe_sync_barrier_pkg;

  localparam int NumCores = 2;

  typedef logic [NumCores-1:0] mask_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,  // disarmed, waiting for any enable
    WAIT    = 3'd1,  // armed, collecting arrivals, timeout running
    RELEASE = 3'd2,  // driving the wake pulse
    DRAIN   = 3'd3,  // waiting for woken cores to leave sleep
    HOLD    = 3'd4   // done; parked until software drops all enables
  } state_e;

endpackage

// File: rtl/safe_sync_barrier.sv
// safe_sync_barrier
// Rendezvous engine for the dual-core safe wrapper. Arms when software sets
// any core<n>sync enable, waits until every enabled core has parked
// (core_sleep high), then wakes all participants together with a common
// pulse. A timeout bounds the wait; an aborted rendezvous still wakes the
// participants but reports timeout instead of sync_done.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   core0sync_i   core 0 participates (register bit)
//   core1sync_i   core 1 participates (register bit)
//   core_sleep_i  per-core "parked at barrier" level, bit0 = core 0,
//                 must already be synchronous to clk_i
//   wake_irq_o    per-core wake pulse, WakePulseCycles wide
//   busy_o        barrier armed (WAIT, RELEASE or DRAIN)
//   sync_done_o   one-cycle pulse after a normal rendezvous has drained
//   timeout_o     sticky abort flag, cleared when all enables return to 0
//   state_o       current sequencer state (observation only)
//
// Core protocol: a core raises core_sleep and holds it until it sees its
// wake_irq bit; it then drops core_sleep. The barrier only finishes (and
// can only re-arm) after every woken core has dropped core_sleep and
// software has cleared all enables.
module safe_sync_barrier
  import safe_sync_barrier_pkg::*;
#(
  parameter int TimeoutCycles   = 1024,
  parameter int WakePulseCycles = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core0sync_i,
  input  logic                core1sync_i,
  input  logic [NumCores-1:0] core_sleep_i,
  output logic [NumCores-1:0] wake_irq_o,
  output logic                busy_o,
  output logic                sync_done_o,
  output logic                timeout_o,
  output state_e              state_o
);

  // The counter serves both the WAIT timeout and the RELEASE pulse width, so
  // it is sized for whichever limit is larger.
  localparam int CntMax = (TimeoutCycles > WakePulseCycles) ? TimeoutCycles : WakePulseCycles;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] PulseLast   = CntW'(WakePulseCycles - 1);
  localparam logic [CntW-1:0] CntSat      = {CntW{1'b1}};

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mask_t           arrived_q, arrived_d;
  mask_t           mask_lat_q, mask_lat_d;
  logic            timeout_q, timeout_d;
  logic            sync_done_q, sync_done_d;

  mask_t           mask;
  mask_t           seen;
  logic            complete;
  logic [CntW-1:0] cnt_inc;

  assign mask = {core1sync_i, core0sync_i};

  // Arrivals so far plus this cycle's sleepers, restricted to the current
  // mask. Masking here drops the arrival bits of cores that software removed
  // and lets a shrinking mask complete in the same cycle.
  assign seen     = (arrived_q | core_sleep_i) & mask;
  assign complete = (seen == mask);

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      arrived_q   <= '0;
      mask_lat_q  <= '0;
      timeout_q   <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arrived_q   <= arrived_d;
      mask_lat_q  <= mask_lat_d;
      timeout_q   <= timeout_d;
      sync_done_q <= sync_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    arrived_d   = arrived_q;
    mask_lat_d  = mask_lat_q;
    timeout_d   = timeout_q;
    sync_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mask != '0) begin
          state_d   = WAIT;
          cnt_d     = '0;
          arrived_d = '0;
        end
      end

      WAIT: begin
        if (mask == '0) begin
          // Software abort: no wake, no status.
          state_d   = IDLE;
          cnt_d     = '0;
          arrived_d = '0;
        end else if (complete) begin
          // Completion has priority over a timeout in the same cycle.
          state_d    = RELEASE;
          cnt_d      = '0;
          arrived_d  = '0;
          mask_lat_d = mask;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = RELEASE;
          cnt_d      = '0;
          arrived_d  = '0;
          mask_lat_d = mask;
          timeout_d  = 1'b1;
        end else begin
          arrived_d = seen;
          cnt_d     = cnt_inc;
        end
      end

      RELEASE: begin
        if (cnt_q == PulseLast) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DRAIN: begin
        if ((core_sleep_i & mask_lat_q) == '0) begin
          sync_done_d = ~timeout_q;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        // Stay here while enables remain set so the same request cannot
        // re-arm the barrier.
        if (mask == '0) begin
          timeout_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wake_irq_o  = (state_q == RELEASE) ? mask_lat_q : '0;
  assign busy_o      = (state_q == WAIT) || (state_q == RELEASE) || (state_q == DRAIN);
  assign sync_done_o = sync_done_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;

endmodule
